// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared widths, reset constants and parity helper for stream_fifo
// Optional parity protection is enabled with STREAM_FIFO_PARITY_EN.
package stream_fifo_pkg;

  localparam int PAR_MAX_W = 64;
  localparam int LEVEL_RST = 0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - write/read handshake bundle for stream_fifo
// slave is the FIFO side, master is the producer/consumer side.
interface stream_fifo_if #(
  parameter int WIDTH = 18
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_fifo_ram.sv
// rtl/stream_fifo_ram.sv - simple dual-port RAM, one write port and one registered read port
// Contents are not reset; the owner tracks which entries hold live data.
module stream_fifo_ram #(
  parameter int WIDTH = 18,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - FWFT stream FIFO with level, almost flags and sticky error status
// Define STREAM_FIFO_PARITY_EN to store and check an even-parity bit per word.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int  WIDTH         = 18,
  parameter int  DEPTH         = 32,
  parameter int  AFULL_MARGIN  = 4,
  parameter int  AEMPTY_THRESH = 1,
  localparam int LW            = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          clr_err,
  stream_fifo_if.slave  bus,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          parity_err
);
  localparam int AW = ptr_w(DEPTH);
`ifdef STREAM_FIFO_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic [LW-1:0]    pipe_cnt;
  logic             in_ready, push, pop, move, ram_re, ram_we;
  logic [RW-1:0]    ram_wdata, ram_rdata;

  assign in_ready = (level_q < DEPTH_L);
  assign push     = bus.in_valid & in_ready;
  assign pop      = out_valid_q & bus.out_ready;
  // Words in flight between RAM and output; anything above this is still unread in RAM.
  assign pipe_cnt = LW'(rd_valid_q) + LW'(out_valid_q);
  assign move     = rd_valid_q & (~out_valid_q | pop);
  assign ram_re   = (level_q > pipe_cnt) & (~rd_valid_q | move);
  assign ram_we   = push & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_valid_d  = rd_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (ram_re) rd_ptr_d = rd_ptr_q + AW'(1);
    if (ram_re) rd_valid_d = 1'b1;
    else if (move) rd_valid_d = 1'b0;
    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata[WIDTH-1:0];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      rd_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
    // A fresh error event outranks a same-cycle clear.
    overflow_d = (overflow_q & ~clr_err) | (bus.in_valid & ~in_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= LW'(LEVEL_RST);
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef STREAM_FIFO_PARITY_EN
  logic par_err_q, par_err_d, par_bad;

  assign ram_wdata = {par_even(PAR_MAX_W'(bus.in_data)), bus.in_data};
  assign par_bad   = move & ~flush &
                     (par_even(PAR_MAX_W'(ram_rdata[WIDTH-1:0])) != ram_rdata[WIDTH]);
  assign par_err_d = (par_err_q & ~clr_err) | par_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign parity_err = par_err_q;
`else
  assign ram_wdata  = bus.in_data;
  assign parity_err = 1'b0;
`endif

  stream_fifo_ram #(
    .WIDTH(RW),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign level         = level_q;
  assign almost_full   = (level_q >= AF_L);
  assign almost_empty  = (level_q <= AE_L);
  assign overflow      = overflow_q;
endmodule
